fetch_unit_q: RTL
=================

Name: fetch_unit_q

Overview:
Parametrised instruction-fetch front end for the RISC-V core.
- Owns the fetch PC and issues word-aligned requests to a synchronous instruction ROM with fixed read latency.
- Buffers returned instructions with their PCs in a small queue, presented to decode over a valid/ready handshake.
- Replaces stall/branch muxing with a single redirect port. The redirect flushes the queue and discards in-flight reads.

Parameters:
XLEN, 32, PC and address width in bits.
RESET_PC, 32'h0000_0000, fetch address after reset. Bits [1:0] must be 0.
QDEPTH, 4, instruction queue depth. Power of 2, minimum 2.
MEM_LAT, 1, ROM read latency in cycles, 1..3.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
redirect_valid  in  1  load new fetch PC, flush queue and in-flight reads
redirect_pc  in  XLEN  target PC; bits [1:0] ignored (treated as 0)
imem_req  out  1  ROM read issued this cycle
imem_addr  out  XLEN-2  word address = fetch_pc[XLEN-1:2]
imem_rdata  in  32  ROM data, valid MEM_LAT cycles after the request
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_inst  out  32  head instruction
out_pc  out  XLEN  head PC
q_count  out  $clog2(QDEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst=0 at a clock edge):
  - fetch_pc <= RESET_PC; queue emptied; in-flight pipeline cleared; epoch <= 0.
  - out_valid=0, q_count=0, imem_req=0 during the reset cycle.
  - out_inst/out_pc are don't-care while out_valid=0.
  - Reset mid-stream overrides redirect and handshake; all in-flight data is lost.
- Credit rule: imem_req=1 when (inflight + q_count + pop_adj) < QDEPTH and no redirect this cycle.
  - inflight = number of valid stages in the latency pipeline.
  - pop_adj = -1 if out_valid & out_ready this cycle.
  - This guarantees a returning word never finds the queue full. A push while full is illegal; the bench asserts it never happens.
- Request pipeline:
  - A request in cycle t shifts {valid, pc, epoch} through MEM_LAT stages.
  - In cycle t+MEM_LAT, imem_rdata plus the tagged pc is pushed at end of cycle if the tag epoch equals the current epoch. Otherwise it is dropped.
- Latency: out_valid first rises in cycle t+MEM_LAT+1 after request cycle t. The first request is issued in the first cycle with rst=1.
- fetch_pc advances by 4 on each issued request, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0 with no flag.
- Queue: circular buffer, QDEPTH entries, pointers wrap mod QDEPTH.
  - Simultaneous push and pop is legal at any occupancy, including full and empty. The count is unchanged.
  - Push into an empty queue becomes visible next cycle; there is no bypass.
- Handshake: the head is consumed when out_valid & out_ready. out_inst/out_pc are stable while out_valid=1 and out_ready=0.
- Redirect (redirect_valid=1 in cycle r):
  - End of cycle r: fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; queue cleared; epoch toggles; no request issued in r.
  - A handshake completing in cycle r counts as consumed. No other entry survives.
  - A response returning in cycle r is dropped.
  - New request issued in r+1. out_valid=0 from r+1 until r+1+MEM_LAT+1.
  - Back-to-back redirects: the last one wins.
- Throughput: one instruction per cycle sustained when out_ready=1 and QDEPTH >= MEM_LAT+1.

Decomposition:
- Shared package core_pkg holds XLEN, RESET_PC default, INST_W=32, and the fetch_entry_t struct {inst, pc}.
- One sub-module: fetch_q_fifo, a parametrised synchronous FIFO with flush. It takes DEPTH and entry width and provides push/pop/flush/count.
- The latency pipeline and credit logic stay in fetch_unit_q.

Test Plan:
1. Reset stream: RESET_PC=0, MEM_LAT=1, out_ready=1 -> imem_addr 0,1,2..., out_valid from cycle 2, out_pc 0,4,8... with one instruction per cycle.
2. Backpressure: out_ready=0 for 10 cycles -> q_count saturates at 4, imem_req drops, no entry lost or duplicated. On release, PCs continue in order.
3. Redirect with in-flight reads: MEM_LAT=3, redirect to 0x100 while 3 reads pending -> no stale out_pc appears, and the first out_pc=0x100 arrives at cycle r+5.
4. Redirect coincident with handshake: head pc 0x8 accepted in the same cycle as redirect to 0x40 -> 0x8 counted once, next out_pc=0x40.
5. Misaligned redirect and wrap: redirect_pc=0xFFFF_FFFE -> out_pc 0xFFFF_FFFC, then 0x0000_0000.
6. Reset mid-operation: rst=0 for one cycle with queue full -> out_valid=0 and q_count=0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide constants and the fetch queue entry type shared by the front end.
package core_pkg;
    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam int              INST_W   = 32;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_q_fifo.sv
// Synchronous circular FIFO with flush. Data is written on push; the head is visible the cycle after the push.
// Backpressure is the caller's job: push while full (without pop) is not guarded here.
module fetch_q_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (i_push && !i_pop)
                r_count <= r_count + CW'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !i_flush && i_push)
            r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
endmodule

// File: rtl/fetch_unit_q.sv
// Fetch front end: credit-limited ROM requests, MEM_LAT-stage tagged return pipe, instruction queue to decode.
// Request-to-out_valid is MEM_LAT+1 cycles; requests stall whenever queue plus in-flight reads would exceed QDEPTH.
module fetch_unit_q
    import core_pkg::*;
#(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int              QDEPTH   = 4,
    parameter int              MEM_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    imem_req,
    output logic [XLEN-3:0]         imem_addr,
    input  logic [INST_W-1:0]       imem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INST_W-1:0]       out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [$clog2(QDEPTH):0] q_count
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = CW + 2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic            r_epoch;
    logic            r_stg_vld [MEM_LAT];
    logic [XLEN-1:0] r_stg_pc  [MEM_LAT];
    logic            r_stg_ep  [MEM_LAT];

    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [CW-1:0]   w_cnt;
    logic [SW-1:0]   w_inflight;
    entry_t          w_push_dat;
    entry_t          w_head_dat;
    logic            w_unused;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++)
            w_inflight = w_inflight + SW'(r_stg_vld[i]);
    end

    assign out_valid = rst && !w_empty;
    assign q_count   = rst ? w_cnt : '0;
    assign w_pop     = out_valid && out_ready;

    // Every in-flight read and every queued word holds a slot, so a return can never meet a full queue.
    assign w_req     = rst && !redirect_valid &&
                       ((w_inflight + SW'(w_cnt)) < (SW'(QDEPTH) + SW'(w_pop)));

    assign w_push    = rst && !redirect_valid && r_stg_vld[MEM_LAT-1] &&
                       (r_stg_ep[MEM_LAT-1] == r_epoch);
    assign w_push_dat.inst = imem_rdata;
    assign w_push_dat.pc   = r_stg_pc[MEM_LAT-1];

    assign imem_req  = w_req;
    assign imem_addr = r_pc[XLEN-1:2];
    assign out_inst  = w_head_dat.inst;
    assign out_pc    = w_head_dat.pc;
    assign w_unused  = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_epoch <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            r_epoch <= ~r_epoch;
        end else if (w_req) begin
            r_pc    <= r_pc + XLEN'(4);
        end
    end

    // Clearing the valids on redirect keeps a 1-bit epoch safe across back-to-back redirects
    // and returns the credit of discarded reads immediately.
    always_ff @(posedge clk) begin
        if (!rst || redirect_valid) begin
            for (int i = 0; i < MEM_LAT; i++)
                r_stg_vld[i] <= 1'b0;
        end else begin
            r_stg_vld[0] <= w_req;
            for (int i = 1; i < MEM_LAT; i++)
                r_stg_vld[i] <= r_stg_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_stg_pc[0] <= r_pc;
        r_stg_ep[0] <= r_epoch;
        for (int i = 1; i < MEM_LAT; i++) begin
            r_stg_pc[i] <= r_stg_pc[i-1];
            r_stg_ep[i] <= r_stg_ep[i-1];
        end
    end

    fetch_q_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_count    (w_cnt),
        .o_empty    (w_empty)
    );
endmodule
